// File: rtl/uart_tx.sv
// UART transmitter: 5-9 data bits, optional parity, 1/2 stop bits, x16/x8 bit timing.
// Optional break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx #(
    parameter int MAX_WORD_LEN = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    txen,
    input  logic [MAX_WORD_LEN-1:0] data,
    input  logic                    wr,
    input  logic [3:0]              wordlen,
    input  logic                    u2x,
    input  logic [1:0]              parity,
    input  logic                    stopbits,
`ifdef UART_TX_BREAK_EN
    input  logic                    sendbreak,
`endif
    output logic                    tx,
    output logic                    busy,
    output logic                    txbufempty,
    output logic                    txdone,
    output logic                    writecollision
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
        , BRK  = 3'd5,
        MARK   = 3'd6
`endif
    } state_t;

    function automatic logic [3:0] eff_len(input logic [3:0] wl);
        if ((wl >= 4'd5) && (wl <= 4'd9)) begin
            return wl;
        end else begin
            return 4'd8;
        end
    endfunction

    // Even parity over the active bits, inverted for odd mode.
    function automatic logic frame_parity(input logic [MAX_WORD_LEN-1:0] d,
                                          input logic [3:0] len,
                                          input logic [1:0] mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < MAX_WORD_LEN; i++) begin
            p = p ^ (d[i] & (i < int'(len)));
        end
        return (mode == 2'd2) ? ~p : p;
    endfunction

    state_t                  state_r, state_nxt;
    logic [3:0]              tick_r, tick_nxt;
    logic [3:0]              bit_cnt_r, bit_cnt_nxt;
    logic [MAX_WORD_LEN-1:0] shift_r, shift_nxt;
    logic [MAX_WORD_LEN-1:0] buf_r, buf_nxt;
    logic [3:0]              len_r, len_nxt;
    logic [1:0]              pmode_r, pmode_nxt;
    logic                    stop_r, stop_nxt;
    logic                    u2x_r, u2x_nxt;
    logic                    par_r, par_nxt;
    logic                    buf_empty_r, buf_empty_nxt;
    logic                    tx_r, tx_nxt;
    logic                    busy_r, busy_nxt;
    logic                    done_r, done_nxt;
    logic                    coll_r, coll_nxt;
    logic                    last_tick_s;
    logic                    load_s;
    logic                    xfer_s;
    logic                    idle_load_s;
    logic [MAX_WORD_LEN-1:0] load_word_s;

    // Next-state, datapath and write handling for the transmitter.
    always_comb begin
        state_nxt     = state_r;
        bit_cnt_nxt   = bit_cnt_r;
        shift_nxt     = shift_r;
        buf_nxt       = buf_r;
        len_nxt       = len_r;
        pmode_nxt     = pmode_r;
        stop_nxt      = stop_r;
        u2x_nxt       = u2x_r;
        par_nxt       = par_r;
        buf_empty_nxt = buf_empty_r;
        tx_nxt        = tx_r;
        busy_nxt      = busy_r;
        done_nxt      = 1'b0;
        coll_nxt      = coll_r;
        load_s        = 1'b0;
        xfer_s        = 1'b0;
        load_word_s   = data;
        last_tick_s   = (tick_r == (u2x_r ? 4'd7 : 4'd15));
        tick_nxt      = ((state_r == IDLE) || last_tick_s) ? 4'd0 : tick_r + 4'd1;
`ifdef UART_TX_BREAK_EN
        idle_load_s   = (state_r == IDLE) && !sendbreak;
`else
        idle_load_s   = (state_r == IDLE);
`endif

        if (!txen) begin
            state_nxt     = IDLE;
            tick_nxt      = 4'd0;
            bit_cnt_nxt   = 4'd0;
            buf_empty_nxt = 1'b1;
            tx_nxt        = 1'b1;
            busy_nxt      = 1'b0;
            coll_nxt      = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (sendbreak) begin
                        state_nxt = BRK;
                        tx_nxt    = 1'b0;
                        busy_nxt  = 1'b1;
                        u2x_nxt   = u2x;
                    end else begin
                        state_nxt = IDLE;
                    end
`else
                    state_nxt = IDLE;
`endif
                end
                START: begin
                    if (last_tick_s) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = 4'd0;
                        tx_nxt      = shift_r[0];
                    end else begin
                        state_nxt = START;
                    end
                end
                DATA: begin
                    if (!last_tick_s) begin
                        state_nxt = DATA;
                    end else if (bit_cnt_r != (len_r - 4'd1)) begin
                        bit_cnt_nxt = bit_cnt_r + 4'd1;
                        shift_nxt   = shift_r >> 1;
                        tx_nxt      = shift_r[1];
                    end else if (pmode_r != 2'd0) begin
                        state_nxt = PARITY;
                        tx_nxt    = par_r;
                    end else begin
                        state_nxt   = STOP;
                        bit_cnt_nxt = 4'd0;
                        tx_nxt      = 1'b1;
                    end
                end
                PARITY: begin
                    if (last_tick_s) begin
                        state_nxt   = STOP;
                        bit_cnt_nxt = 4'd0;
                        tx_nxt      = 1'b1;
                    end else begin
                        state_nxt = PARITY;
                    end
                end
                STOP: begin
                    if (!last_tick_s) begin
                        state_nxt = STOP;
                    end else if (bit_cnt_r[0] != stop_r) begin
                        bit_cnt_nxt = bit_cnt_r + 4'd1;
                    end else if (!buf_empty_r) begin
                        xfer_s        = 1'b1;
                        load_s        = 1'b1;
                        load_word_s   = buf_r;
                        buf_empty_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
`ifdef UART_TX_BREAK_EN
                BRK: begin
                    if (!sendbreak) begin
                        state_nxt = MARK;
                        tick_nxt  = 4'd0;
                        tx_nxt    = 1'b1;
                    end else begin
                        state_nxt = BRK;
                    end
                end
                MARK: begin
                    if (!last_tick_s) begin
                        state_nxt = MARK;
                    end else if (!buf_empty_r) begin
                        xfer_s        = 1'b1;
                        load_s        = 1'b1;
                        load_word_s   = buf_r;
                        buf_empty_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
`endif
                default: begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                end
            endcase

            // A write in the same edge as a buffer-to-shifter transfer refills the buffer.
            if (!wr) begin
                coll_nxt = coll_r;
            end else if (idle_load_s) begin
                load_s      = 1'b1;
                load_word_s = data;
                coll_nxt    = 1'b0;
            end else if (buf_empty_r || xfer_s) begin
                buf_nxt       = data;
                buf_empty_nxt = 1'b0;
                coll_nxt      = 1'b0;
            end else begin
                coll_nxt = 1'b1;
            end

            if (load_s) begin
                state_nxt = START;
                shift_nxt = load_word_s;
                len_nxt   = eff_len(wordlen);
                pmode_nxt = parity;
                stop_nxt  = stopbits;
                u2x_nxt   = u2x;
                par_nxt   = frame_parity(load_word_s, eff_len(wordlen), parity);
                tx_nxt    = 1'b0;
                busy_nxt  = 1'b1;
                tick_nxt  = 4'd0;
            end else begin
                shift_nxt = shift_nxt;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            tick_r      <= 4'd0;
            bit_cnt_r   <= 4'd0;
            shift_r     <= '0;
            buf_r       <= '0;
            len_r       <= 4'd8;
            pmode_r     <= 2'd0;
            stop_r      <= 1'b0;
            u2x_r       <= 1'b0;
            par_r       <= 1'b0;
            buf_empty_r <= 1'b1;
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            coll_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            tick_r      <= tick_nxt;
            bit_cnt_r   <= bit_cnt_nxt;
            shift_r     <= shift_nxt;
            buf_r       <= buf_nxt;
            len_r       <= len_nxt;
            pmode_r     <= pmode_nxt;
            stop_r      <= stop_nxt;
            u2x_r       <= u2x_nxt;
            par_r       <= par_nxt;
            buf_empty_r <= buf_empty_nxt;
            tx_r        <= tx_nxt;
            busy_r      <= busy_nxt;
            done_r      <= done_nxt;
            coll_r      <= coll_nxt;
        end
    end

    assign tx             = tx_r;
    assign busy           = busy_r;
    assign txbufempty     = buf_empty_r;
    assign txdone         = done_r;
    assign writecollision = coll_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shapes, buffering, collisions, aborts, optional break.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       txen;
    logic [8:0] data;
    logic       wr;
    logic [3:0] wordlen;
    logic       u2x;
    logic [1:0] parity;
    logic       stopbits;
`ifdef UART_TX_BREAK_EN
    logic       sendbreak;
`endif
    logic       tx, busy, txbufempty, txdone, writecollision;

    int vectors = 0;
    int miscompares = 0;

    uart_tx #(.MAX_WORD_LEN(9)) dut (
        .clk(clk),
        .rst(rst),
        .txen(txen),
        .data(data),
        .wr(wr),
        .wordlen(wordlen),
        .u2x(u2x),
        .parity(parity),
        .stopbits(stopbits),
`ifdef UART_TX_BREAK_EN
        .sendbreak(sendbreak),
`endif
        .tx(tx),
        .busy(busy),
        .txbufempty(txbufempty),
        .txdone(txdone),
        .writecollision(writecollision)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [3:0] wl, input logic [1:0] par, input logic sb, input logic x2);
        wordlen  = wl;
        parity   = par;
        stopbits = sb;
        u2x      = x2;
    endtask

    task automatic load(input logic [8:0] d);
        data = d;
        wr   = 1'b1;
        tick();
        wr   = 1'b0;
    endtask

    // Checks {txdone,busy,tx} over every cycle of a frame; bits[] is LSB-first line order.
    task automatic run_frame(input string tag, input logic [15:0] bits, input int nbits,
                             input int cpb, input int wr_at, input logic [8:0] wd,
                             input int wr_at2, input logic [8:0] wd2);
        logic [2:0] obs;
        logic [2:0] exp;
        logic       bad;
        int         k;
        for (int b = 0; b < nbits; b++) begin
            exp = {1'b0, 1'b1, bits[b]};
            obs = exp;
            bad = 1'b0;
            for (int c = 0; c < cpb; c++) begin
                k = b * cpb + c;
                if (!bad && ({txdone, busy, tx} !== exp)) begin
                    obs = {txdone, busy, tx};
                    bad = 1'b1;
                end
                wr = 1'b0;
                if (k == wr_at) begin
                    wr = 1'b1; data = wd;
                end
                if (k == wr_at2) begin
                    wr = 1'b1; data = wd2;
                end
                tick();
            end
            wr = 1'b0;
            check($sformatf("%s bit%0d", tag, b), {29'd0, obs}, {29'd0, exp});
        end
    endtask

    logic bad;

    initial begin
        rst = 1'b0; txen = 1'b0; data = 9'd0; wr = 1'b0;
`ifdef UART_TX_BREAK_EN
        sendbreak = 1'b0;
`endif
        cfg(4'd8, 2'd0, 1'b0, 1'b0);
        tick(); tick();
        check("reset outputs", {27'd0, tx, busy, txbufempty, txdone, writecollision}, 32'b10100);
        rst = 1'b1; txen = 1'b1;
        tick();

        // 8N1 x16: 0x55
        load(9'h055);
        run_frame("t1 0x55", 16'h02AA, 10, 16, -1, 9'd0, -1, 9'd0);
        check("t1 end", {29'd0, txdone, busy, tx}, 32'b101);
        tick();
        check("t1 done pulse", {29'd0, txdone, busy, tx}, 32'b001);

        // 9 bits odd parity, 2 stop, x8
        cfg(4'd9, 2'd2, 1'b1, 1'b1);
        load(9'h0A7);
        run_frame("t2 0xA7", 16'h194E, 13, 8, -1, 9'd0, -1, 9'd0);
        check("t2 end", {29'd0, txdone, busy, tx}, 32'b101);
        tick();

        // out-of-range wordlen falls back to 8; bit 8 ignored
        cfg(4'd3, 2'd0, 1'b0, 1'b1);
        load(9'h155);
        run_frame("wl fallback", 16'h02AA, 10, 8, -1, 9'd0, -1, 9'd0);
        check("wl end", {29'd0, txdone, busy, tx}, 32'b101);
        tick();

        // back-to-back, 7 bits even parity
        cfg(4'd7, 2'd1, 1'b0, 1'b1);
        load(9'h031);
        run_frame("t3 0x31", 16'h0362, 10, 8, 20, 9'h032, -1, 9'd0);
        check("t3 bufempty", {31'd0, txbufempty}, 32'd1);
        run_frame("t3 0x32", 16'h0364, 10, 8, -1, 9'd0, -1, 9'd0);
        check("t3 end", {29'd0, txdone, busy, tx}, 32'b101);
        tick();

        // collision: A sent, B buffered, C dropped, D clears flag
        cfg(4'd8, 2'd0, 1'b0, 1'b1);
        load(9'h041);
        run_frame("t4 A", 16'h0282, 10, 8, 10, 9'h042, 20, 9'h043);
        check("t4 collision", {31'd0, writecollision}, 32'd1);
        run_frame("t4 B", 16'h0284, 10, 8, -1, 9'd0, -1, 9'd0);
        check("t4 end", {28'd0, txdone, busy, tx, writecollision}, 32'b1011);
        tick();
        load(9'h044);
        check("t4 D clears", {30'd0, busy, writecollision}, 32'b10);

        // soft abort via txen with a pending buffer
        load(9'h045);
        check("t5 buffered", {31'd0, txbufempty}, 32'd0);
        repeat (20) tick();
        txen = 1'b0;
        tick();
        check("t5 txen abort", {28'd0, tx, busy, txbufempty, writecollision}, 32'b1010);
        txen = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
            tick();
        end
        check("t5 idle after txen", {31'd0, bad}, 32'd0);

        // async reset mid-bit with a pending buffer
        load(9'h046);
        load(9'h047);
        repeat (12) tick();
        #2 rst = 1'b0;
        #1;
        check("t5 async reset", {28'd0, tx, busy, txbufempty, writecollision}, 32'b1010);
        tick(); tick();
        rst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
            tick();
        end
        check("t5 idle after rst", {31'd0, bad}, 32'd0);

`ifdef UART_TX_BREAK_EN
        // 40-cycle break with a buffered 0x00, then mark and frame
        cfg(4'd8, 2'd0, 1'b0, 1'b0);
        sendbreak = 1'b1;
        load(9'h000);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            if (i == 39) sendbreak = 1'b0;
            tick();
        end
        check("t6 break low", {31'd0, bad}, 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (tx !== 1'b1 || busy !== 1'b1) bad = 1'b1;
            tick();
        end
        check("t6 mark", {31'd0, bad}, 32'd0);
        run_frame("t6 0x00", 16'h0200, 10, 16, -1, 9'd0, -1, 9'd0);
        check("t6 end", {29'd0, txdone, busy, tx}, 32'b101);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
